// File: rtl/instr_fetch_if.sv
// Opcode type shared with decode, and the instruction-memory request/grant +
// in-order response bus used by instr_fetch.
package instr_fetch_pkg;
  typedef enum logic [6:0] {
    OP_LOAD     = 7'h03,
    OP_MISC_MEM = 7'h0F,
    OP_IMM      = 7'h13,
    OP_AUIPC    = 7'h17,
    OP_STORE    = 7'h23,
    OP_REG      = 7'h33,
    OP_LUI      = 7'h37,
    OP_BRANCH   = 7'h63,
    OP_JALR     = 7'h67,
    OP_JAL      = 7'h6F,
    OP_SYSTEM   = 7'h73
  } opcode_e;
endpackage

interface instr_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (output imem_req_o, imem_addr_o,
                  input  imem_gnt_i, imem_rvalid_i, imem_rdata_i);
  modport slave  (input  imem_req_o, imem_addr_o,
                  output imem_gnt_i, imem_rvalid_i, imem_rdata_i);
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch unit: PC, credit-limited imem requests, registered instruction FIFO,
// redirect flush. Define FETCH_MISALIGN_TRAP_EN to halt on misaligned redirect targets.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  instr_fetch_if.master        imem,
  input  logic                 redirect_i,
  input  logic [31:0]          redirect_pc_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [31:0]          instr_o,
  output logic [31:0]          instr_pc_o,
  output opcode_e              op_o,
  output logic                 misalign_o
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned CW      = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [31:0]   pc;
  logic [31:0]   instr_q [DEPTH];
  logic [31:0]   pc_q    [DEPTH];
  logic [31:0]   tag_q   [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, tag_wr, tag_rd;
  logic [CW-1:0] fifo_cnt, outstanding, outstanding_nxt, discard;
  logic          halted, head_vld, gnt, rsp, push, pop;

  // Credits cover both buffered words and in-flight (incl. to-be-discarded) reads,
  // so a response always has a slot and rvalid never needs backpressure.
  assign imem.imem_req_o  = !rst_i && !halted &&
                            (({1'b0, outstanding} + {1'b0, fifo_cnt}) < DEPTH_C);
  assign imem.imem_addr_o = pc;

  assign gnt      = imem.imem_req_o && imem.imem_gnt_i;
  assign rsp      = imem.imem_rvalid_i;
  assign head_vld = !rst_i && (fifo_cnt != '0);
  assign push     = rsp && (discard == '0) && !redirect_i;
  assign pop      = head_vld && instr_ready_i && !redirect_i;

  assign outstanding_nxt = outstanding + CW'(gnt) - CW'(rsp);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc          <= RESET_PC;
      fifo_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      // The tag queue tracks every granted read, discarded or not, so it stays
      // aligned with the in-order response stream across redirects.
      if (gnt) tag_wr <= tag_wr + AW'(1);
      if (rsp) tag_rd <= tag_rd + AW'(1);
      outstanding <= outstanding_nxt;
      if (redirect_i) begin
        pc       <= redirect_pc_i & ~32'h3;
        fifo_cnt <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        discard  <= outstanding_nxt;
      end else begin
        if (gnt)                    pc      <= pc + 32'd4;
        if (rsp && discard != '0)   discard <= discard - CW'(1);
        if (push)                   wr_ptr  <= wr_ptr + AW'(1);
        if (pop)                    rd_ptr  <= rd_ptr + AW'(1);
        fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (gnt) tag_q[tag_wr] <= pc;
    if (push) begin
      instr_q[wr_ptr] <= imem.imem_rdata_i;
      pc_q[wr_ptr]    <= tag_q[tag_rd];
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until reset or an aligned redirect; in-flight reads still drain.
  always_ff @(posedge clk_i) begin
    if (rst_i)           halted <= 1'b0;
    else if (redirect_i) halted <= |redirect_pc_i[1:0];
  end
  assign misalign_o = halted;
`else
  assign halted     = 1'b0;
  assign misalign_o = 1'b0;
`endif

  assign instr_valid_o = head_vld;
  assign instr_o       = head_vld ? instr_q[rd_ptr] : NOP;
  assign instr_pc_o    = pc_q[rd_ptr];
  assign op_o          = opcode_e'(instr_o[6:0]);

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: in-order memory model with variable latency,
// expected {pc, instr} queued on grant, flushed on redirect, compared on pop.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  opcode_e     op;
  logic        misalign;

  instr_fetch_if imem_bus();

  instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .imem(imem_bus),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc),
    .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
    .instr_o(instr), .instr_pc_o(instr_pc), .op_o(op), .misalign_o(misalign)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } exp_t;

  mreq_t mem_q[$];
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    cyc = 0, lat = 1, checks = 0, fails = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_0F1E;
  endfunction

  // One clock: responses leave the memory model in order once due.
  task automatic step();
    @(posedge clk); #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_bus.imem_rvalid_i = 1'b1;
      imem_bus.imem_rdata_i  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else begin
      imem_bus.imem_rvalid_i = 1'b0;
      imem_bus.imem_rdata_i  = '0;
    end
    #1;
  endtask

  task automatic redir(logic [31:0] t);
    redirect = 1'b1; redirect_pc = t;
    step();
    redirect = 1'b0;
  endtask

  // Scoreboard: compare on pop, enqueue on grant, drop everything on redirect.
  always @(negedge clk) begin
    if (!rst) begin
      if (!instr_valid) chk("nop_idle", instr, NOP);
      else if (exp_q.size() == 0) chk("spurious_valid", 32'(instr_valid), 32'd0);
      else if (instr_ready && !redirect) begin
        mon_e = exp_q.pop_front();
        chk("instr_pc", instr_pc, mon_e.pc);
        chk("instr", instr, mon_e.instr);
        chk("op", 32'(op), 32'(mon_e.instr[6:0]));
      end
      if (imem_bus.imem_req_o && imem_bus.imem_gnt_i) begin
        mem_q.push_back('{imem_bus.imem_addr_o, cyc + lat});
        exp_q.push_back('{imem_bus.imem_addr_o, mem_word(imem_bus.imem_addr_o)});
      end
      if (redirect) exp_q.delete();
    end
  end

  initial begin
    logic [31:0] exp_addr, a, t;
    bit found;
    imem_bus.imem_gnt_i    = 1'b0;
    imem_bus.imem_rvalid_i = 1'b0;
    imem_bus.imem_rdata_i  = '0;

    step(); step();
    chk("rst_req", 32'(imem_bus.imem_req_o), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, NOP);
    chk("rst_misalign", 32'(misalign), 32'd0);

    // Reset release, 1-cycle memory, sequential fetch with wrap past FFFF_FFFC.
    rst = 1'b0; instr_ready = 1'b1; imem_bus.imem_gnt_i = 1'b1; lat = 1;
    #1;
    exp_addr = RESET_PC;
    for (int k = 0; k < 12; k++) begin
      if (k == 0) chk("first_req", 32'(imem_bus.imem_req_o), 32'd1);
      if (k == 1) chk("valid_c1", 32'(instr_valid), 32'd0);
      if (k == 2) chk("valid_c2", 32'(instr_valid), 32'd1);
      if (imem_bus.imem_req_o) begin
        chk("fetch_addr", imem_bus.imem_addr_o, exp_addr);
        exp_addr += 32'd4;
      end
      step();
    end

    // Decode stall: credits cap the in-flight + buffered reads.
    instr_ready = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("stall_req", 32'(imem_bus.imem_req_o), 32'd0);
    chk("stall_valid", 32'(instr_valid), 32'd1);
    chk("stall_inflight", 32'(exp_q.size() <= DEPTH), 32'd1);

    // Resume with no grants: request held, address stable.
    instr_ready = 1'b1; imem_bus.imem_gnt_i = 1'b0;
    step(); step(); step();
    a = imem_bus.imem_addr_o;
    chk("hold_req", 32'(imem_bus.imem_req_o), 32'd1);
    step();
    chk("hold_addr", imem_bus.imem_addr_o, a);
    imem_bus.imem_gnt_i = 1'b1;

    // 3-cycle memory, redirect with two reads in flight.
    lat = 3;
    for (int k = 0; k < 8; k++) step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (mem_q.size() == 2 && !imem_bus.imem_rvalid_i) found = 1'b1;
      else step();
    end
    chk("lat3_two_inflight", 32'(found), 32'd1);
    redir(32'h0000_0100);
    chk("redir_addr", imem_bus.imem_addr_o, 32'h0000_0100);
    chk("redir_valid", 32'(instr_valid), 32'd0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (instr_valid) found = 1'b1;
      else step();
    end
    chk("redir_wait_valid", 32'(found), 32'd1);
    chk("redir_first_pc", instr_pc, 32'h0000_0100);

    // Redirect coinciding with a grant and a response.
    lat = 1;
    for (int k = 0; k < 4; k++) step();
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (imem_bus.imem_req_o && imem_bus.imem_rvalid_i) found = 1'b1;
      else step();
    end
    chk("gnt_rsp_found", 32'(found), 32'd1);
    redir(32'h0000_0200);
    chk("redir2_addr", imem_bus.imem_addr_o, 32'h0000_0200);
    chk("redir2_valid", 32'(instr_valid), 32'd0);

    // Random grants, decode stalls, latencies and aligned redirects.
    for (int k = 0; k < 300; k++) begin
      imem_bus.imem_gnt_i = ($urandom_range(0, 9) < 7);
      instr_ready         = ($urandom_range(0, 9) < 6);
      lat                 = $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) begin
        t = $urandom(); t[1:0] = 2'b00;
        redirect = 1'b1; redirect_pc = t;
      end else redirect = 1'b0;
      step();
    end
    redirect = 1'b0; imem_bus.imem_gnt_i = 1'b1; instr_ready = 1'b1; lat = 1;
    for (int k = 0; k < 4; k++) step();

    // Misaligned redirect target.
    redir(32'h0000_0102);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(misalign), 32'd1);
    for (int k = 0; k < 4; k++) begin
      chk("mis_no_req", 32'(imem_bus.imem_req_o), 32'd0);
      step();
    end
    chk("mis_valid", 32'(instr_valid), 32'd0);
    redir(32'h0000_0300);
    chk("mis_clear", 32'(misalign), 32'd0);
    chk("mis_resume_req", 32'(imem_bus.imem_req_o), 32'd1);
    chk("mis_resume_addr", imem_bus.imem_addr_o, 32'h0000_0300);
`else
    chk("mis_addr", imem_bus.imem_addr_o, 32'h0000_0100);
    chk("mis_flag", 32'(misalign), 32'd0);
`endif
    for (int k = 0; k < 6; k++) step();

    // Drain: nothing lost, nothing left.
    imem_bus.imem_gnt_i = 1'b0;
    for (int k = 0; k < 10; k++) step();
    chk("drain_exp", 32'(exp_q.size()), 32'd0);
    chk("drain_mem", 32'(mem_q.size()), 32'd0);
    chk("drain_valid", 32'(instr_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the RV32I core: owns the PC, issues word reads to instruction memory over a request/grant + in-order response interface, buffers returned words in a small FIFO, and presents instruction, PC and opcode field to decode under a valid/ready handshake. It is the producer side of the `op_i` path into `main_decoder`, and it accepts control-flow redirects from branch/jump resolution, flushing stale fetches.

## Interface
- `RESET_PC`, `32'h0000_0000`, PC fetched first after reset.
- `DEPTH`, `2`, FIFO entries and maximum in-flight requests; power of two, ≥ 2.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `imem_req_o` out 1: read request valid.
- `imem_addr_o` out 32: word address of the request, bits [1:0] always 0.
- `imem_gnt_i` in 1: request accepted this cycle.
- `imem_rvalid_i` in 1: response data valid; responses return in request order, ≥ 1 cycle after grant.
- `imem_rdata_i` in 32: response instruction word.
- `redirect_i` in 1: control-flow redirect.
- `redirect_pc_i` in 32: redirect target.
- `instr_valid_o` out 1: FIFO head valid.
- `instr_ready_i` in 1: decode accepts head.
- `instr_o` out 32: head instruction; `32'h0000_0013` (NOP) when not valid.
- `instr_pc_o` out 32: PC of head instruction.
- `op_o` out `opcode_e`: `instr_o[6:0]`.
- `misalign_o` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- State: `pc` (next fetch address), FIFO of {instr, pc} (`DEPTH` entries), `outstanding` (granted, not yet returned), `discard` (returns to drop), `halted`.
- `imem_req_o = !halted && (outstanding + fifo_count) < DEPTH`; `imem_addr_o = pc`. Credit rule guarantees every response has a FIFO slot; no backpressure on `imem_rvalid_i`.
- Grant without redirect: `pc += 4` (mod 2^32, wraps `32'hFFFF_FFFC` → 0), `outstanding++`, PC of request queued in an in-order PC tag queue.
- Response: `outstanding--`; if `discard > 0`, `discard--` and word dropped; else {rdata, tagged pc} pushed.
- Pop on `instr_valid_o && instr_ready_i`.
- Redirect (`redirect_i` high): FIFO flushed (including a same-cycle push; a same-cycle pop is void), `discard` ← `outstanding` after this cycle's grant/response accounting (a grant this cycle is discarded; a response this cycle is dropped), `pc` ← `redirect_pc_i` with bits [1:0] cleared. Redirect takes priority over all other updates.
- Simultaneous grant + response: `outstanding` unchanged.
- New fetches after redirect may be issued while `discard > 0`; credit rule counts discarded in-flight requests.

## Timing
- Reset (`rst_i` high at edge): `pc = RESET_PC`, FIFO empty, `outstanding = discard = 0`, `halted = 0`, `misalign_o = 0`. During reset cycle `imem_req_o = 0`, `instr_valid_o = 0`, `instr_o = NOP`. Reset mid-transaction abandons all in-flight responses; the memory side must be reset concurrently.
- First `imem_req_o` in the first cycle with `rst_i` low, address `RESET_PC`.
- Response in cycle n → `instr_valid_o` in cycle n+1 (registered FIFO); no combinational rdata→instr path.
- Redirect in cycle n → `imem_addr_o = redirect_pc_i` in cycle n+1; `instr_valid_o` low in n+1.
- Sustained throughput: one instruction/cycle with single-cycle memory and `DEPTH ≥ 2`.
- `imem_req_o` combinational from state only (not from `imem_gnt_i`); `imem_addr_o` stable while req held without grant.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `redirect_pc_i[1:0] != 0` sets `halted` and `misalign_o` (sticky until reset or an aligned redirect, which clears both and resumes); no requests while halted; outstanding responses still drained/discarded.
- Undefined: low two bits silently cleared, fetch continues, `misalign_o` tied 0, `halted` never set.

## Test plan
- Reset release, 1-cycle memory, ready=1 → addresses 0,4,8,… one per cycle; first `instr_valid_o` two cycles after first req; `op_o` matches `imem_rdata_i[6:0]`.
- `instr_ready_i = 0` for 10 cycles → at most `DEPTH` (2) grants outstanding+buffered, `imem_req_o` drops, no word lost; resume yields in-order PCs.
- 3-cycle memory latency, redirect to `32'h0000_0100` with 2 requests outstanding → both returns dropped, next valid instruction has `instr_pc_o = 32'h100`.
- Redirect same cycle as grant and response → both discarded, `imem_addr_o = target` next cycle.
- `RESET_PC = 32'hFFFF_FFF8` → fetches FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Redirect to `32'h0000_0102`: with macro → `misalign_o = 1`, `imem_req_o = 0` until aligned redirect; without → fetch at `32'h100`.
